l1_refill_ctrl: RTL

L1 miss/refill controller that consumes the one-hot victim way from the random replacement unit.
- On a miss it latches the victim way.
- If the victim line is dirty, it writes that line back to L2 word by word.
- It then fetches the missing line from L2 into the victim way and updates tag/valid/dirty.
- It sits between the L1 tag/data arrays, the replacement unit and the L2 request port.

---
 rtl/l1_refill_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/l1_refill_ctrl.sv
// L1 miss/refill controller: optional dirty-line writeback to L2, then a line
// fill from L2 into the victim way chosen by the replacement unit.
module l1_refill_ctrl #(
  parameter int unsigned WAY_NUM    = 4,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                          clk_l1,
  input  logic                          rst_n,
  input  logic                          miss_req,
  input  logic [ADDR_W-1:0]             miss_addr,
  input  logic [WAY_NUM-1:0]            replace_way,
  input  logic [WAY_NUM-1:0]            victim_dirty,
  input  logic [ADDR_W-1:0]             victim_addr,
  output logic [WAY_NUM-1:0]            arr_way,
  output logic [$clog2(LINE_WORDS)-1:0] arr_word,
  input  logic [DATA_W-1:0]             arr_rdata,
  output logic                          arr_we,
  output logic [DATA_W-1:0]             arr_wdata,
  output logic                          tag_we,
  output logic                          l2_req,
  output logic                          l2_we,
  output logic [ADDR_W-1:0]             l2_addr,
  output logic [DATA_W-1:0]             l2_wdata,
  input  logic                          l2_ack,
  input  logic [DATA_W-1:0]             l2_rdata,
  output logic                          refill_busy,
  output logic                          refill_done
);

  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS * BYTES);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [WORD_W-1:0] K_LAST    = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, WB_RD, WB_REQ, FILL_REQ, FILL_WR, UPDATE, DONE
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   k_q, k_d;
  logic [WAY_NUM-1:0]  way_q, way_d, way_sel_c;
  logic [ADDR_W-1:0]   miss_line_q, miss_line_d;
  logic [ADDR_W-1:0]   wb_line_q, wb_line_d;
  logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
  logic [DATA_W-1:0]   wb_buf_q, wb_buf_d;
  logic [DATA_W-1:0]   fill_buf_q, fill_buf_d;
  logic                arr_we_q, arr_we_d;
  logic                tag_we_q, tag_we_d;
  logic                l2_req_q, l2_req_d;
  logic                l2_we_q, l2_we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dirty_c;

  // Lowest set bit of the victim vector; an empty vector falls back to way 0.
  assign way_sel_c = (replace_way == '0) ? WAY_NUM'(1)
                                         : (replace_way & (~replace_way + WAY_NUM'(1)));
  assign dirty_c   = |(victim_dirty & replace_way);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    way_d       = way_q;
    miss_line_d = miss_line_q;
    wb_line_d   = wb_line_q;
    wb_buf_d    = wb_buf_q;
    fill_buf_d  = fill_buf_q;
    arr_we_d    = 1'b0;
    tag_we_d    = 1'b0;
    l2_req_d    = 1'b0;
    l2_we_d     = 1'b0;
    l2_addr_d   = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_req) begin
          way_d       = way_sel_c;
          miss_line_d = miss_addr & LINE_MASK;
          wb_line_d   = victim_addr & LINE_MASK;
          k_d         = '0;
          state_d     = dirty_c ? WB_RD : FILL_REQ;
        end
      end
      WB_RD: begin
        wb_buf_d = arr_rdata;
        state_d  = WB_REQ;
      end
      WB_REQ: begin
        if (l2_ack) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = FILL_REQ;
          end else begin
            k_d     = k_q + WORD_W'(1);
            state_d = WB_RD;
          end
        end
      end
      FILL_REQ: begin
        if (l2_ack) begin
          fill_buf_d = l2_rdata;
          state_d    = FILL_WR;
        end
      end
      FILL_WR: begin
        if (k_q == K_LAST) begin
          state_d = UPDATE;
        end else begin
          k_d     = k_q + WORD_W'(1);
          state_d = FILL_REQ;
        end
      end
      UPDATE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with state_q.
    arr_we_d = (state_d == FILL_WR);
    tag_we_d = (state_d == UPDATE);
    done_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE);
    l2_req_d = (state_d == WB_REQ) || (state_d == FILL_REQ);
    l2_we_d  = (state_d == WB_REQ);
    if (state_d == WB_REQ) begin
      l2_addr_d = wb_line_d + ADDR_W'(k_d) * ADDR_W'(BYTES);
    end else if (state_d == FILL_REQ) begin
      l2_addr_d = miss_line_d + ADDR_W'(k_d) * ADDR_W'(BYTES);
    end
  end

  always_ff @(posedge clk_l1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      way_q       <= '0;
      miss_line_q <= '0;
      wb_line_q   <= '0;
      wb_buf_q    <= '0;
      fill_buf_q  <= '0;
      arr_we_q    <= 1'b0;
      tag_we_q    <= 1'b0;
      l2_req_q    <= 1'b0;
      l2_we_q     <= 1'b0;
      l2_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      way_q       <= way_d;
      miss_line_q <= miss_line_d;
      wb_line_q   <= wb_line_d;
      wb_buf_q    <= wb_buf_d;
      fill_buf_q  <= fill_buf_d;
      arr_we_q    <= arr_we_d;
      tag_we_q    <= tag_we_d;
      l2_req_q    <= l2_req_d;
      l2_we_q     <= l2_we_d;
      l2_addr_q   <= l2_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign arr_way     = way_q;
  assign arr_word    = k_q;
  assign arr_we      = arr_we_q;
  assign arr_wdata   = fill_buf_q;
  assign tag_we      = tag_we_q;
  assign l2_req      = l2_req_q;
  assign l2_we       = l2_we_q;
  assign l2_addr     = l2_addr_q;
  assign l2_wdata    = wb_buf_q;
  assign refill_busy = busy_q;
  assign refill_done = done_q;

endmodule
